// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding and FSM states.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Bit of op that selects the 32-bit word variant.
  localparam int OP_W = 3;

  // Most-negative 32-bit value, used for the word-op overflow check.
  localparam logic signed [31:0] W_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int W = 64
) (
  input  logic [W:0]   rem_in,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // Trial subtraction carries one extra bit so its sign is exact.
  always_comb begin
    shifted = {rem_in, dvd_msb};
    trial   = shifted - {2'b00, divisor};
    q_bit   = ~trial[W+1];
    rem_out = q_bit ? trial[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit (radix-2 shift-add / restoring divide).
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// BUSY  | one multiply or divide iteration per cycle, counter N-1 down to 0
// FIX   | sign correction, high/low select, word sign-extension; result registered
// DONE  | out_valid high, holding result until out_ready
//
// Divide special cases (by zero, signed overflow) skip BUSY and pass through FIX with
// preloaded quotient/remainder and no negation, so out_valid rises one edge after accept.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam int SH = XLEN - 32;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                w_q, w_d, neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d, opb_q, opb_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                out_valid_q, out_valid_d;

  logic [2:0]          f3_in;
  logic                w_in, is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic signed [31:0]  a_lo, b_lo, fix_lo;
  logic [XLEN-1:0]     a_ext, b_ext, a_abs, b_abs, min_val;
  logic [XLEN:0]       step_rem;
  logic                step_q;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

  div_step #(.W(XLEN)) u_div_step (
    .rem_in  (rem_q),
    .dvd_msb (quo_q[XLEN-1]),
    .divisor (opb_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Decode the incoming request: operand extension, magnitudes and special cases.
  always_comb begin
    f3_in  = op[2:0];
    w_in   = (XLEN == 64) && op[OP_W];
    is_div = f3_in[2];
    a_sgn  = is_div ? ~f3_in[0] : ((f3_in == F3_MULH) || (f3_in == F3_MULHSU));
    b_sgn  = is_div ? ~f3_in[0] : (f3_in == F3_MULH);
    a_lo   = rs1[31:0];
    b_lo   = rs2[31:0];
    a_ext  = rs1;
    b_ext  = rs2;
    if (w_in) begin
      if (a_sgn) a_ext = XLEN'(a_lo);
      else       a_ext = XLEN'(rs1[31:0]);
      if (b_sgn) b_ext = XLEN'(b_lo);
      else       b_ext = XLEN'(rs2[31:0]);
    end
    a_neg   = a_sgn && a_ext[XLEN-1];
    b_neg   = b_sgn && b_ext[XLEN-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    min_val = {1'b1, {(XLEN-1){1'b0}}};
    if (w_in) min_val = XLEN'(W_MIN);
    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && !f3_in[0] && (a_ext == min_val) && (b_ext == '1);
  end

  // Final result: sign correction, high/low or quotient/remainder select, word extension.
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    quo_fix = neg_q ? -quo_q : quo_q;
    rem_fix = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (f3_q[2])              fix_res = f3_q[1] ? rem_fix : quo_fix;
    else if (f3_q == F3_MUL)  fix_res = prod[XLEN-1:0];
    else                      fix_res = prod[2*XLEN-1:XLEN];
    fix_lo = fix_res[31:0];
    if (w_q) fix_res = XLEN'(fix_lo);
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    w_d         = w_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    opb_d       = opb_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    in_ready    = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          f3_d    = f3_in;
          w_d     = w_in;
          cnt_d   = w_in ? CW'(31) : CW'(XLEN - 1);
          acc_d   = '0;
          rem_d   = '0;
          opb_d   = b_abs;
          // Word operands are pre-aligned so iteration always consumes the MSB.
          quo_d   = w_in ? (a_abs << SH) : a_abs;
          neg_d   = (is_div && f3_in[1]) ? a_neg : (a_neg ^ b_neg);
          state_d = BUSY;
          if (div_zero || div_ovf) begin
            neg_d   = 1'b0;
            quo_d   = div_zero ? '1 : a_ext;
            rem_d   = div_zero ? {1'b0, rs1} : '0;
            state_d = FIX;
          end
        end
      end
      BUSY: begin
        if (f3_q[2]) begin
          rem_d = step_rem;
          quo_d = {quo_q[XLEN-2:0], step_q};
        end else begin
          acc_d = (acc_q << 1) + {{XLEN{1'b0}}, opb_q & {XLEN{quo_q[XLEN-1]}}};
          quo_d = quo_q << 1;
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        result_d    = fix_res;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      w_q         <= 1'b0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      w_q         <= w_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=64): directed ops push expected result and
// out_valid rise edge; a monitor checks each output as the DUT presents it.
module tb_muldiv_unit;

  localparam logic [3:0] OP_MUL = 4'h0, OP_MULH = 4'h1, OP_MULHSU = 4'h2, OP_MULHU = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4, OP_DIVU = 4'h5, OP_REM = 4'h6, OP_REMU = 4'h7;
  localparam logic [3:0] OP_MULW = 4'h8, OP_DIVW = 4'hC, OP_DIVUW = 4'hD, OP_REMW = 4'hE;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] res;
    int          rise;
    string       name;
  } exp_t;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [63:0] rs1, rs2, result;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e_mon;
  logic ov_prev = 1'b0;

  muldiv_unit #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: check out_valid rise timing and the result on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out_valid at_edge=%0d required=no_output", cyc);
        end else if (cyc != sb[0].rise) begin
          failures++;
          $display("FAIL %s_latency rise_edge=%0d required=%0d", sb[0].name, cyc, sb[0].rise);
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e_mon = sb.pop_front();
        checks++;
        if (result !== e_mon.res) begin
          failures++;
          $display("FAIL %s_result got=%h required=%h", e_mon.name, result, e_mon.res);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input string nm, input bit push);
    int   budget;
    exp_t e;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout in_ready=%0b required=1", nm, in_ready);
      return;
    end
    in_valid = 1'b1;
    op  = o;
    rs1 = a;
    rs2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op  = ~o;
    rs1 = ~a;
    rs2 = ~b;
    if (push) begin
      e.res  = exp;
      e.rise = cyc + lat;
      e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout pending=%0d required=0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout sim_time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; out_ready = 1'b1;
    #3;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    issue(OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7x-3", 1);
    issue(OP_MULHU,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_ones", 1);
    issue(OP_MULH,   ONES, ONES, 64'd0, 65, "mulh_-1x-1", 1);
    issue(OP_MULHSU, ONES, 64'd2, ONES, 65, "mulhsu_-1x2", 1);
    issue(OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_-7/2", 1);
    issue(OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, "rem_-7/2", 1);
    issue(OP_DIVU,   64'd100, 64'd7, 64'd14, 65, "divu_100/7", 1);
    issue(OP_REMU,   64'd100, 64'd7, 64'd2, 65, "remu_100/7", 1);
    issue(OP_DIVU,   64'd5, 64'd0, ONES, 1, "divu_by0", 1);
    issue(OP_REMU,   64'd5, 64'd0, 64'd5, 1, "remu_by0", 1);
    issue(OP_DIV,    64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1, "div_ovf", 1);
    issue(OP_REM,    64'h8000_0000_0000_0000, ONES, 64'd0, 1, "rem_ovf", 1);
    issue(OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw", 1);
    issue(OP_DIVW,   64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1, "divw_ovf", 1);
    issue(OP_DIVUW,  64'hFFFF_FFFF_0000_0064, 64'hABCD_0000_0000_0007, 64'd14, 33, "divuw", 1);
    issue(OP_REMW,   64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 33, "remw", 1);
    wait_drain("directed");

    // Backpressure: result and handshake held while out_ready is low.
    out_ready = 1'b0;
    issue(OP_DIVU, 64'd1000, 64'd10, 64'd100, 65, "divu_backpressure", 1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("bp_out_valid_seen", {63'd0, seen}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_result_stable", result, 64'd100);
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("backpressure");
    @(negedge clk);
    chk("bp_after_handoff_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_after_handoff_in_ready", {63'd0, in_ready}, 64'd1);

    // Flush while BUSY with the counter at 20.
    issue(OP_MUL, 64'd3, 64'd4, 64'd12, 65, "mul_flushed", 0);
    repeat (43) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("flush_no_out_valid", {63'd0, seen}, 64'd0);

    // Flush beats a simultaneous request in IDLE.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = OP_MUL; rs1 = 64'd5; rs2 = 64'd5;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush_beats_in_valid", {63'd0, in_ready}, 64'd1);
    issue(OP_MULHU, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65, "mulhu_after_flush", 1);
    wait_drain("after_flush");

    // Reset mid-BUSY clears outputs immediately; next op completes.
    issue(OP_DIV, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 65, "div_reset", 0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(OP_DIV, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FF9C, 65, "div_after_rst", 1);
    wait_drain("after_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
